// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_arb_pkg;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_WAIT = 4;

  // One-hot style encoding so each rvalid decodes from a single flop bit.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_CPU  = 2'b01,
    OWN_EXT  = 2'b10
  } owner_e;

  // Which port owns the read data returning next cycle; writes return nothing.
  function automatic owner_e next_owner(input logic cpu_rd, input logic ext_rd);
    if (cpu_rd) begin
      return OWN_CPU;
    end
    if (ext_rd) begin
      return OWN_EXT;
    end
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, external-requester and memory-side signals around the arbiter.
// Latency: n/a (wiring only); slave = arbiter view, master = requesters plus memory.
// Backpressure: cpu_stall / ext_gnt carry the arbitration result back to requesters.
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  // CPU (MEM stage) port
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  // External (debug loader / DMA) port
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [DATA_W-1:0] ext_rdata;

  // Single-ported data memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating count of consecutive cycles the external port lost arbitration.
// Latency: expired reflects the registered count, so it is valid at cycle start.
// Backpressure: none; clr wins over inc, count holds at MAX_WAIT and never wraps.
module dmem_starve_ctr import dmem_arb_pkg::*; #(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;

  // Count lost cycles, saturating; any grant or dropped request restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (clr) begin
      wait_cnt <= '0;
    end else if (inc && (wait_cnt != CNT_MAX)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign expired = (wait_cnt == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-ported data memory between the CPU MEM stage and an external port.
// Latency: issue is combinational in the request cycle; read data returns 1 cycle later.
// Backpressure: CPU wins ties and gets cpu_stall when it loses; ext_req is held until ext_gnt.
// Optional DMEM_ARB_STARVE_EN: forces an external grant after MAX_WAIT lost cycles.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  logic              cpu_sel;
  logic              ext_sel;
  logic              expired;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  owner_e            owner;

  // A zero wait budget would let the external port override the CPU every cycle.
  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be at least 1");
  end

`ifdef DMEM_ARB_STARVE_EN
  logic wait_inc;
  logic wait_clr;

  // The counter only advances while the external port is asking and losing.
  assign wait_inc = bus.ext_req & ~ext_sel;
  assign wait_clr = ext_sel | ~bus.ext_req;

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc     (wait_inc),
    .clr     (wait_clr),
    .expired (expired)
  );
`else
  // Strict CPU priority: the external port can wait forever.
  assign expired = 1'b0;
`endif

  // Pick the issuing port: CPU wins ties unless the external port has waited too long.
  always_comb begin
    ext_sel = bus.ext_req & (~bus.cpu_req | expired);
    cpu_sel = bus.cpu_req & ~ext_sel;
  end

  // Steer the selected port's command onto the memory; idle cycles default to the CPU fields.
  always_comb begin
    sel_we    = bus.cpu_we;
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    if (ext_sel) begin
      sel_we    = bus.ext_we;
      sel_addr  = bus.ext_addr;
      sel_wdata = bus.ext_wdata;
    end
  end

  assign bus.mem_en    = cpu_sel | ext_sel;
  assign bus.mem_we    = bus.mem_en & sel_we;
  assign bus.mem_addr  = sel_addr;
  assign bus.mem_wdata = sel_wdata;

  assign bus.ext_gnt   = ext_sel;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_sel;

  // Remember which port issued a read so its data is flagged on the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner <= OWN_NONE;
    end else begin
      owner <= next_owner(cpu_sel & ~bus.cpu_we, ext_sel & ~bus.ext_we);
    end
  end

  // Each rvalid is a single bit of the owner register; both data buses see the memory directly.
  assign bus.cpu_rvalid = (owner == OWN_CPU);
  assign bus.ext_rvalid = (owner == OWN_EXT);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.ext_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a cycle-level reference model.
// Latency: model expects read data one cycle after issue.
// Backpressure: external requests are held until granted, as the protocol requires.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .MAX_WAIT (MW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Synchronous single-port memory behind the arbiter (low 8 address bits used).
  bit [31:0] phys_mem [256];
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) phys_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= phys_mem[bus.mem_addr[7:0]];
    end
  end

  // Reference model state
  bit [31:0] ref_mem [256];
  int        m_wait;
  int        m_pend;       // 0 = no response due, 1 = CPU, 2 = external
  bit [31:0] m_pend_data;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check everything the model predicts, advance the model.
  task automatic step(input bit rst,
                      input bit creq, input bit cwe, input bit [31:0] caddr, input bit [31:0] cwd,
                      input bit ereq, input bit ewe, input bit [31:0] eaddr, input bit [31:0] ewd,
                      output bit granted);
    bit force_ext, e_ext, e_cpu;
    @(negedge clk);
    reset         = rst;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.ext_req   = ereq;
    bus.ext_we    = ewe;
    bus.ext_addr  = eaddr;
    bus.ext_wdata = ewd;
    #1;
    if (rst) begin
      m_pend = 0;
      m_wait = 0;
    end
    // responses from the previous cycle's issue
    check_eq("cpu_rvalid", bus.cpu_rvalid, m_pend == 1);
    check_eq("ext_rvalid", bus.ext_rvalid, m_pend == 2);
    if (m_pend == 1) check_eq("cpu_rdata", bus.cpu_rdata, m_pend_data);
    if (m_pend == 2) check_eq("ext_rdata", bus.ext_rdata, m_pend_data);
    check_eq("rvalid_both", bus.cpu_rvalid & bus.ext_rvalid, 0);
    // arbitration for this cycle
`ifdef DMEM_ARB_STARVE_EN
    force_ext = (m_wait >= MW);
`else
    force_ext = 1'b0;
`endif
    e_ext = ereq && (!creq || force_ext);
    e_cpu = creq && !e_ext;
    check_eq("mem_en", bus.mem_en, e_cpu || e_ext);
    check_eq("ext_gnt", bus.ext_gnt, e_ext);
    check_eq("cpu_stall", bus.cpu_stall, creq && !e_cpu);
    if (e_cpu) begin
      check_eq("mem_we_cpu", bus.mem_we, cwe);
      check_eq("mem_addr_cpu", bus.mem_addr, caddr);
      if (cwe) check_eq("mem_wdata_cpu", bus.mem_wdata, cwd);
    end
    if (e_ext) begin
      check_eq("mem_we_ext", bus.mem_we, ewe);
      check_eq("mem_addr_ext", bus.mem_addr, eaddr);
      if (ewe) check_eq("mem_wdata_ext", bus.mem_wdata, ewd);
    end
    // state after the coming edge
    m_pend = 0;
    if (e_cpu) begin
      if (cwe) ref_mem[caddr[7:0]] = cwd;
      else begin
        m_pend      = 1;
        m_pend_data = ref_mem[caddr[7:0]];
      end
    end
    if (e_ext) begin
      if (ewe) ref_mem[eaddr[7:0]] = ewd;
      else begin
        m_pend      = 2;
        m_pend_data = ref_mem[eaddr[7:0]];
      end
    end
    if (ereq && !e_ext) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
    else                m_wait = 0;
    if (rst) begin
      m_pend = 0;
      m_wait = 0;
    end
    granted = e_ext;
  endtask

  // Expected ext_gnt in a run where both ports request every cycle from a zero count.
  function automatic bit both_busy_gnt(input int i);
`ifdef DMEM_ARB_STARVE_EN
    return (i % (MW + 1)) == MW;
`else
    return (i < 0);
`endif
  endfunction

  initial begin
    bit g;
    bit eh, ewe_h, creq, cwe;
    bit [31:0] ea, ew, ca, cw;
    n_checks = 0;
    n_errors = 0;
    m_pend   = 0;
    m_wait   = 0;
    reset         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = '0;
    bus.ext_wdata = '0;

    // reset state; issue logic follows requests even in reset
    step(1, 0,0,0,0, 0,0,0,0, g);
    step(1, 1,0,32'h4,0, 0,0,0,0, g);
    check_eq("rst_mem_en", bus.mem_en, 1);
    step(0, 0,0,0,0, 0,0,0,0, g);

    // preload 0x10 through the external port, then CPU-only load
    step(0, 0,0,0,0, 1,1,32'h10,32'hDEADBEEF, g);
    step(0, 1,0,32'h10,0, 0,0,0,0, g);
    check_eq("tp1_mem_en", bus.mem_en, 1);
    check_eq("tp1_stall", bus.cpu_stall, 0);
    step(0, 0,0,0,0, 0,0,0,0, g);
    check_eq("tp1_rvalid", bus.cpu_rvalid, 1);
    check_eq("tp1_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check_eq("tp1_ext_rvalid", bus.ext_rvalid, 0);

    // external write then read of 0x20
    step(0, 0,0,0,0, 1,1,32'h20,32'h12345678, g);
    check_eq("tp2_wr_gnt", bus.ext_gnt, 1);
    step(0, 0,0,0,0, 1,0,32'h20,0, g);
    check_eq("tp2_rd_gnt", bus.ext_gnt, 1);
    step(0, 0,0,0,0, 0,0,0,0, g);
    check_eq("tp2_rvalid", bus.ext_rvalid, 1);
    check_eq("tp2_rdata", bus.ext_rdata, 32'h12345678);

    // both ports busy every cycle
    for (int i = 0; i < 10; i++) begin
      step(0, 1,0,32'h40 + i,0, 1,0,32'h80 + i,0, g);
      check_eq("tp3_gnt", bus.ext_gnt, both_busy_gnt(i));
      check_eq("tp3_stall", bus.cpu_stall, both_busy_gnt(i));
    end
    step(0, 0,0,0,0, 0,0,0,0, g);

    // strictly alternating CPU / external reads
    for (int k = 0; k < 4; k++) begin
      step(0, 1,0,32'h10,0, 0,0,0,0, g);
      if (k > 0) begin
        check_eq("tp5_ext_rvalid", bus.ext_rvalid, 1);
        check_eq("tp5_ext_rdata", bus.ext_rdata, 32'h12345678);
      end
      step(0, 0,0,0,0, 1,0,32'h20,0, g);
      check_eq("tp5_cpu_rvalid", bus.cpu_rvalid, 1);
      check_eq("tp5_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    end
    step(0, 0,0,0,0, 0,0,0,0, g);
    check_eq("tp5_ext_rvalid_last", bus.ext_rvalid, 1);

    // reset right after a CPU read issue (external port also losing)
    step(0, 1,0,32'h10,0, 1,0,32'h30,0, g);
    step(1, 0,0,0,0, 0,0,0,0, g);
    check_eq("tp6_drop", bus.cpu_rvalid, 0);
    step(0, 0,0,0,0, 0,0,0,0, g);
    check_eq("tp6_no_rvalid", bus.cpu_rvalid, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1,0,32'h50 + i,0, 1,0,32'h90,0, g);
      check_eq("tp6_gnt", bus.ext_gnt, both_busy_gnt(i));
    end
    step(0, 0,0,0,0, 0,0,0,0, g);

    // randomized traffic with varying CPU load, held external requests, rare resets
    eh = 1'b0; ewe_h = 1'b0; ea = '0; ew = '0;
    for (int i = 0; i < 3000; i++) begin
      int dens;
      bit rst;
      dens = (i / 300) % 5;
      creq = ($urandom_range(1, 4) <= dens);
      cwe  = $urandom_range(0, 1);
      ca   = $urandom_range(0, 255);
      cw   = $urandom;
      if (!eh && ($urandom_range(0, 2) == 0)) begin
        eh    = 1'b1;
        ewe_h = $urandom_range(0, 1);
        ea    = $urandom_range(0, 255);
        ew    = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
      step(rst, creq, cwe, ca, cw, eh, ewe_h, ea, ew, g);
      if (g || rst) eh = 1'b0;
    end
    step(0, 0,0,0,0, 0,0,0,0, g);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
